// File: rtl/guess_tracker_pkg.sv
// mm_pkg: shared round-state and guess-result encodings for the Memory Matrix tracker.
package mm_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_WIN  = 2'b10,
      ST_LOSE = 2'b11
   } state_t;
   typedef enum logic [1:0] {
      RES_MISS   = 2'b00,
      RES_HIT    = 2'b01,
      RES_REPEAT = 2'b10,
      RES_BADIDX = 2'b11
   } res_t;
endpackage

// File: rtl/guess_counter.sv
// guess_counter: loadable saturating down-counter holding the remaining miss budget.
module guess_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic [CNT_W-1:0] count,
   output logic             zero
);
   assign zero = count == '0;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) count <= '0;
      else if (load) count <= load_val;
      else if (dec && !zero) count <= count - CNT_W'(1);
   end
endmodule

// File: rtl/guess_tracker.sv
// guess_tracker: one Memory Matrix round - latched board, found tiles, miss budget, round FSM.
module guess_tracker
   import mm_pkg::*;
#(
   parameter int BOARD_W = 25,
   parameter int IDX_W   = 5,
   parameter int CNT_W   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [BOARD_W-1:0] board,
   input  logic [CNT_W-1:0]   guess_limit,
   input  logic               guess_valid,
   input  logic [IDX_W-1:0]   guess_idx,
   output logic               guess_ready,
   output logic               res_valid,
   output logic [1:0]         res_code,
   output logic [BOARD_W-1:0] found_mask,
   output logic [CNT_W-1:0]   hits,
   output logic [CNT_W-1:0]   remaining,
   output logic [1:0]         state
);
   localparam logic [IDX_W:0] IDX_LIMIT = (IDX_W+1)'(BOARD_W);
   state_t             state_q, state_d;
   res_t               code, res_code_q;
   logic [BOARD_W-1:0] board_q, found_q, found_d, sel;
   logic [CNT_W-1:0]   hits_q;
   logic               res_valid_q, idx_ok, on_board, already, accept, hit, miss, last_miss, rem_zero;
   // A one-hot select keeps out-of-range indices harmless: the shift simply yields zero.
   assign sel       = BOARD_W'(1) << guess_idx;
   assign idx_ok    = {1'b0, guess_idx} < IDX_LIMIT;
   assign on_board  = |(board_q & sel);
   assign already   = |(found_q & sel);
   assign code      = !idx_ok ? RES_BADIDX : !on_board ? RES_MISS : already ? RES_REPEAT : RES_HIT;
   assign accept    = guess_valid && state_q == ST_PLAY && !start;
   assign hit       = accept && code == RES_HIT;
   assign miss      = accept && code == RES_MISS;
   assign found_d   = hit ? (found_q | sel) : found_q;
   assign last_miss = miss && remaining <= CNT_W'(1);
   guess_counter #(.CNT_W(CNT_W)) u_remaining (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .load_val (guess_limit),
      .dec      (miss),
      .count    (remaining),
      .zero     (rem_zero)
   );
   always_comb begin
      state_d = state_q;
      if (start) state_d = board == '0 ? ST_WIN : guess_limit == '0 ? ST_LOSE : ST_PLAY;
      else if (accept) state_d = found_d == board_q ? ST_WIN : last_miss ? ST_LOSE : ST_PLAY;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else state_q <= state_d;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         board_q     <= '0;
         found_q     <= '0;
         hits_q      <= '0;
         res_valid_q <= 1'b0;
         res_code_q  <= RES_MISS;
      end else begin
         res_valid_q <= accept;
         if (start) begin
            board_q <= board;
            found_q <= '0;
            hits_q  <= '0;
         end else if (accept) begin
            found_q    <= found_d;
            res_code_q <= code;
            if (hit) hits_q <= hits_q + CNT_W'(1);
         end
      end
   end
   assign guess_ready = state_q == ST_PLAY;
   assign res_valid   = res_valid_q;
   assign res_code    = res_code_q;
   assign found_mask  = found_q;
   assign hits        = hits_q;
   assign state       = state_q;
endmodule

// File: tb/tb_guess_tracker.sv
// tb_guess_tracker: directed and random rounds checked against a tile-array model of the game.
module tb_guess_tracker;
   localparam int BW = 25, IW = 5, CW = 8;
   logic          clk = 1'b0, reset = 1'b0, start = 1'b0, guess_valid = 1'b0;
   logic [BW-1:0] board = '0;
   logic [CW-1:0] guess_limit = '0;
   logic [IW-1:0] guess_idx = '0;
   logic          guess_ready, res_valid;
   logic [1:0]    res_code, state;
   logic [BW-1:0] found_mask;
   logic [CW-1:0] hits, remaining;
   int   total = 0, bad = 0;
   bit   m_board[BW], m_found[BW], m_rv;
   int   m_rem, m_state;
   logic [1:0] m_code = 2'b00;
   guess_tracker #(.BOARD_W(BW), .IDX_W(IW), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .start(start), .board(board), .guess_limit(guess_limit),
      .guess_valid(guess_valid), .guess_idx(guess_idx), .guess_ready(guess_ready),
      .res_valid(res_valid), .res_code(res_code), .found_mask(found_mask), .hits(hits),
      .remaining(remaining), .state(state)
   );
   always #5 clk = ~clk;
   function automatic logic [BW-1:0] m_found_vec();
      logic [BW-1:0] v = '0;
      for (int i = 0; i < BW; i++) v[i] = m_found[i];
      return v;
   endfunction
   function automatic logic [BW-1:0] m_board_vec();
      logic [BW-1:0] v = '0;
      for (int i = 0; i < BW; i++) v[i] = m_board[i];
      return v;
   endfunction
   function automatic int m_hits();
      int n = 0;
      for (int i = 0; i < BW; i++) n += int'(m_found[i]);
      return n;
   endfunction
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic check_all(input string tag);
      chk({tag, ".state"}, 64'(state), 64'(m_state));
      chk({tag, ".guess_ready"}, 64'(guess_ready), 64'(m_state == 1));
      chk({tag, ".res_valid"}, 64'(res_valid), 64'(m_rv));
      chk({tag, ".res_code"}, 64'(res_code), 64'(m_code));
      chk({tag, ".found_mask"}, 64'(found_mask), 64'(m_found_vec()));
      chk({tag, ".hits"}, 64'(hits), 64'(m_hits()));
      chk({tag, ".remaining"}, 64'(remaining), 64'(m_rem));
   endtask
   task automatic model_reset();
      for (int i = 0; i < BW; i++) begin m_board[i] = 0; m_found[i] = 0; end
      m_rem = 0; m_state = 0; m_code = 2'b00; m_rv = 0;
   endtask
   task automatic do_start(input logic [BW-1:0] b, input logic [CW-1:0] lim, input bit with_guess,
                           input logic [IW-1:0] idx, input string tag);
      @(negedge clk);
      start = 1'b1; board = b; guess_limit = lim; guess_valid = with_guess; guess_idx = idx;
      @(posedge clk); #1;
      start = 1'b0; guess_valid = 1'b0;
      for (int i = 0; i < BW; i++) begin m_board[i] = b[i]; m_found[i] = 0; end
      m_rem = int'(lim); m_rv = 0;
      m_state = (b == '0) ? 2 : (lim == '0) ? 3 : 1;
      check_all(tag);
   endtask
   task automatic model_guess(input logic [IW-1:0] idx, input bit valid);
      m_rv = 0;
      if (valid && m_state == 1) begin
         m_rv = 1;
         if (int'(idx) >= BW) m_code = 2'b11;
         else if (!m_board[idx]) begin
            m_code = 2'b00;
            if (m_rem > 0) m_rem--;
         end else if (m_found[idx]) m_code = 2'b10;
         else begin
            m_code = 2'b01;
            m_found[idx] = 1;
         end
         if (m_found_vec() == m_board_vec()) m_state = 2;
         else if (m_code == 2'b00 && m_rem == 0) m_state = 3;
      end
   endtask
   task automatic do_guess(input logic [IW-1:0] idx, input bit valid, input string tag);
      @(negedge clk);
      guess_valid = valid; guess_idx = idx;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      model_guess(idx, valid);
      check_all(tag);
   endtask
   initial begin
      logic [BW-1:0] rb;
      logic [IW-1:0] ri;
      model_reset();
      repeat (2) @(posedge clk);
      #1 check_all("reset");
      @(negedge clk) reset = 1'b1;
      do_guess(5'd0, 1'b1, "idle_ignored");
      do_start(25'h0000013, 8'd3, 1'b0, 5'd0, "start_a");
      do_guess(5'd0, 1'b1, "hit0");
      do_guess(5'd1, 1'b1, "hit1");
      do_guess(5'd4, 1'b1, "hit4_win");
      do_guess(5'd2, 1'b1, "win_frozen");
      do_start(25'h0000013, 8'd3, 1'b0, 5'd0, "start_b");
      do_guess(5'd2, 1'b1, "miss2");
      do_guess(5'd3, 1'b1, "miss3");
      do_guess(5'd5, 1'b1, "miss5_lose");
      do_guess(5'd0, 1'b1, "lose_frozen");
      do_start(25'h0000013, 8'd3, 1'b0, 5'd0, "start_c");
      do_guess(5'd0, 1'b1, "hit_first");
      do_guess(5'd0, 1'b1, "repeat");
      do_guess(5'd30, 1'b1, "badidx");
      do_guess(5'd25, 1'b1, "badidx_edge");
      do_guess(5'd24, 1'b1, "miss_top_tile");
      do_start(25'h0, 8'd5, 1'b0, 5'd0, "empty_board_win");
      do_start(25'h1, 8'd0, 1'b0, 5'd0, "zero_limit_lose");
      do_start(25'h0000013, 8'd3, 1'b0, 5'd0, "start_d");
      do_guess(5'd0, 1'b1, "hit_before_restart");
      do_start(25'h0000013, 8'd4, 1'b1, 5'd0, "start_with_guess");
      do_guess(5'd0, 1'b0, "no_result_after_start");
      do_start(25'h0000013, 8'd3, 1'b0, 5'd0, "start_e");
      @(negedge clk);
      guess_valid = 1'b1; guess_idx = 5'd2;
      @(posedge clk); #1;
      guess_valid = 1'b0;
      model_guess(5'd2, 1'b1);
      check_all("pre_reset");
      #2 reset = 1'b0;
      #1 model_reset();
      check_all("async_reset");
      @(negedge clk) reset = 1'b1;
      #1 check_all("after_reset");
      for (int r = 0; r < 40; r++) begin
         rb = BW'($urandom & $urandom & $urandom);
         if ($urandom_range(0, 9) == 0) rb = '0;
         do_start(rb, CW'($urandom_range(0, 6)), $urandom_range(0, 3) == 0, IW'($urandom_range(0, 31)), "rnd_start");
         for (int s = 0; s < 40 && m_state == 1; s++) begin
            ri = ($urandom_range(0, 1) == 0) ? IW'($urandom_range(0, 31)) : IW'($urandom_range(0, 6));
            if ($urandom_range(0, 29) == 0)
               do_start(BW'($urandom | 1), CW'($urandom_range(1, 6)), 1'b1, ri, "rnd_restart");
            else
               do_guess(ri, $urandom_range(0, 3) != 0, "rnd_guess");
         end
         do_guess(IW'($urandom_range(0, 24)), 1'b1, "rnd_after_end");
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
